// File: rtl/audio_pkg.sv
// Shared types and constants for the audio PWM output stage.
package audio_pkg;

  // Playback state: IDLE (amp off, FIFO flushed), PRIME (filling), PLAY (consuming)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } audio_state_e;

  localparam int DEFAULT_SAMPLE_W   = 8;
  localparam int DEFAULT_CLK_DIV    = 2500;  // 25 MHz / 10 kHz
  localparam int DEFAULT_FIFO_DEPTH = 16;

  // Unsigned PCM midscale, i.e. the zero-signal level for a given width.
  function automatic int midscale(input int sample_w);
    return 1 << (sample_w - 1);
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO with push/pop/flush, first-word-fall-through read.
// Pointers carry one extra wrap bit so full and empty are told apart.
module audio_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; flush wins over any push or pop in the same cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Sample storage.
  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/audio_pwm_output.sv
// Audio PWM output stage: buffers PCM samples, pops one per sample period and
// renders it as glitch-free PWM; drives amplifier shutdown and a sticky underrun flag.
// Optional build macro AUDIO_PWM_VOLUME_EN adds Volume_In (arithmetic-shift attenuation
// around midscale); without it the popped sample is used unchanged as the duty.
module audio_pwm_output
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                        Master_Clock_In,
  input  logic                        Master_Reset_N_In,
  input  logic                        Enable_In,
  input  logic [SAMPLE_W-1:0]         Sample_In,
  input  logic                        Sample_Valid_In,
  output logic                        Sample_Ready_Out,
  input  logic                        Clear_Underrun_In,
`ifdef AUDIO_PWM_VOLUME_EN
  input  logic [2:0]                  Volume_In,
`endif
  output logic                        Audio_Pwm_Out,
  output logic                        Audio_Sd_N_Out,
  output logic                        Underrun_Out,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_Level_Out
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(midscale(SAMPLE_W));

  logic clk, rst_n;
  assign clk   = Master_Clock_In;
  assign rst_n = Master_Reset_N_In;

  audio_state_e        state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [SAMPLE_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [SAMPLE_W-1:0] duty_next_q, duty_next_d;
  logic [SAMPLE_W-1:0] duty_active_q, duty_active_d;
  logic                pwm_q, pwm_d;
  logic                underrun_q, underrun_d;

  logic                tick, underrun_set;
  logic                fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LVL_W-1:0]    fifo_level;
  logic [SAMPLE_W-1:0] fifo_rd_data, scaled_sample;

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (Sample_In),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Ready depends only on registered state, never on valid.
  assign Sample_Ready_Out = (state_q != IDLE) && !fifo_full;
  assign fifo_push        = Sample_Valid_In && Sample_Ready_Out;
  assign fifo_flush       = !Enable_In || (state_q == IDLE);
  assign tick             = (state_q != IDLE) && (div_cnt_q == DIV_W'(CLK_DIV - 1));

`ifdef AUDIO_PWM_VOLUME_EN
  logic signed [SAMPLE_W:0] centred, attenuated;
  // Attenuate around midscale; the signed shift keeps the result inside the sample range.
  always_comb begin
    centred       = $signed({1'b0, fifo_rd_data}) - $signed({1'b0, MID});
    attenuated    = centred >>> Volume_In;
    scaled_sample = SAMPLE_W'(attenuated + $signed({1'b0, MID}));
  end
`else
  assign scaled_sample = fifo_rd_data;
`endif

  // Playback state machine, pop request, duty selection and underrun flag.
  always_comb begin
    state_d      = state_q;
    duty_next_d  = duty_next_q;
    underrun_d   = underrun_q;
    underrun_set = 1'b0;
    fifo_pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        duty_next_d = MID;
        state_d     = PRIME;
      end
      PRIME: begin
        duty_next_d = MID;
        if (fifo_level >= LVL_W'(FIFO_DEPTH / 2)) state_d = PLAY;
      end
      PLAY: begin
        if (tick) begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            duty_next_d = scaled_sample;
          end else begin
            underrun_set = 1'b1;
            duty_next_d  = MID;
            state_d      = PRIME;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Disable overrides everything: the in-flight sample is dropped.
    if (!Enable_In) begin
      state_d      = IDLE;
      duty_next_d  = MID;
      fifo_pop     = 1'b0;
      underrun_set = 1'b0;
    end
    // A new underrun beats a simultaneous clear.
    if (underrun_set)           underrun_d = 1'b1;
    else if (Clear_Underrun_In) underrun_d = 1'b0;
  end

  // Sample-period divider, free PWM counter and wrap-aligned duty reload.
  always_comb begin
    div_cnt_d     = (fifo_flush || tick) ? '0 : div_cnt_q + DIV_W'(1);
    pwm_cnt_d     = pwm_cnt_q + SAMPLE_W'(1);
    duty_active_d = (pwm_cnt_q == '1) ? duty_next_q : duty_active_q;
    pwm_d         = Enable_In && (state_q != IDLE) && (pwm_cnt_q < duty_active_q);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      duty_next_q   <= MID;
      duty_active_q <= MID;
      pwm_q         <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_next_q   <= duty_next_d;
      duty_active_q <= duty_active_d;
      pwm_q         <= pwm_d;
      underrun_q    <= underrun_d;
    end
  end

  assign Audio_Pwm_Out  = pwm_q;
  assign Audio_Sd_N_Out = (state_q != IDLE);
  assign Underrun_Out   = underrun_q;
  assign Fifo_Level_Out = fifo_level;

endmodule

// File: tb/tb_audio_pwm_output.sv
// Self-checking bench for audio_pwm_output: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based behavioural model.
module tb_audio_pwm_output;
  import audio_pkg::*;

  localparam int SW    = 8;
  localparam int DIV   = 300;
  localparam int DEPTH = 16;
  localparam int MIDV  = 128;
  localparam int PER   = 256;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       enable = 1'b0, valid = 1'b0, clr = 1'b0;
  logic [7:0] sample = '0;
`ifdef AUDIO_PWM_VOLUME_EN
  logic [2:0] volume = '0;
`endif
  logic       ready, pwm, sd_n, underrun;
  logic [4:0] level;

  int total = 0;
  int bad   = 0;

  always #20 clk = ~clk;

  audio_pwm_output #(
    .SAMPLE_W   (SW),
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .Master_Clock_In   (clk),
    .Master_Reset_N_In (rst_n),
    .Enable_In         (enable),
    .Sample_In         (sample),
    .Sample_Valid_In   (valid),
    .Sample_Ready_Out  (ready),
    .Clear_Underrun_In (clr),
`ifdef AUDIO_PWM_VOLUME_EN
    .Volume_In         (volume),
`endif
    .Audio_Pwm_Out     (pwm),
    .Audio_Sd_N_Out    (sd_n),
    .Underrun_Out      (underrun),
    .Fifo_Level_Out    (level)
  );

  // Behavioural model: sample queue, elapsed-time counters and the duty pair.
  audio_state_e m_state;
  logic [7:0]   m_q[$];
  int           m_act, m_abs, m_duty_next, m_duty_active, m_pushes;
  bit           m_pwm, m_underrun;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int shape(input int s);
`ifdef AUDIO_PWM_VOLUME_EN
    return MIDV + ((s - MIDV) >>> volume);
`else
    return s;
`endif
  endfunction

  task automatic model_reset();
    m_state       = IDLE;
    m_q.delete();
    m_act         = 0;
    m_abs         = 0;
    m_duty_next   = MIDV;
    m_duty_active = MIDV;
    m_pwm         = 1'b0;
    m_underrun    = 1'b0;
  endtask

  // What one rising edge does, from the inputs and model state just before it.
  task automatic model_edge();
    bit           rdy, push, tick, under;
    int           phase;
    audio_state_e prev;
    prev  = m_state;
    rdy   = (m_state != IDLE) && (m_q.size() < DEPTH);
    push  = valid && rdy;
    tick  = (m_state != IDLE) && (m_act % DIV == DIV - 1);
    phase = m_abs % PER;
    under = 1'b0;
    m_pwm = enable && (m_state != IDLE) && (phase < m_duty_active);
    if (phase == PER - 1) m_duty_active = m_duty_next;
    if (!enable) begin
      m_state = IDLE;
      m_q.delete();
      m_duty_next = MIDV;
    end else begin
      case (m_state)
        IDLE: begin
          m_state = PRIME;
          m_q.delete();
          m_duty_next = MIDV;
        end
        PRIME: begin
          m_duty_next = MIDV;
          if (m_q.size() >= DEPTH / 2) m_state = PLAY;
        end
        default: begin
          if (tick) begin
            if (m_q.size() > 0) m_duty_next = shape(int'(m_q.pop_front()));
            else begin
              under       = 1'b1;
              m_duty_next = MIDV;
              m_state     = PRIME;
            end
          end
        end
      endcase
      if (push) begin
        m_q.push_back(sample);
        m_pushes++;
      end
    end
    m_act = (!enable || prev == IDLE) ? 0 : m_act + 1;
    if (under)    m_underrun = 1'b1;
    else if (clr) m_underrun = 1'b0;
    m_abs++;
  endtask

  // One clock: advance the model at the edge, compare all outputs on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("ready", ready, (m_state != IDLE) && (m_q.size() < DEPTH));
    check("sd_n", sd_n, m_state != IDLE);
    check("level", level, m_q.size());
    check("underrun", underrun, m_underrun);
    check("pwm", pwm, m_pwm);
  endtask

  task automatic push_n(input int n, input logic [7:0] value);
    int start, guard;
    start  = m_pushes;
    guard  = 0;
    sample = value;
    valid  = 1'b1;
    while (m_pushes - start < n && guard < 1000) begin
      cycle();
      guard++;
    end
    valid = 1'b0;
    check("tmo_push", int'(guard < 1000), 1);
  endtask

  // Align to a PWM period boundary, then count high clocks over one full period.
  task automatic measure_highs(output int highs);
    int guard;
    guard = 0;
    highs = 0;
    do begin
      cycle();
      guard++;
    end while (m_abs % PER != 0 && guard < 300);
    for (int i = 0; i < PER; i++) begin
      cycle();
      highs += int'(pwm);
    end
  endtask

  initial begin
    int highs, guard;
    bit saw_full;
    m_pushes = 0;
    model_reset();

    // Reset values, then disabled with valid held high.
    #30;
    check("rst_pwm", pwm, 0);
    check("rst_sdn", sd_n, 0);
    check("rst_ready", ready, 0);
    check("rst_under", underrun, 0);
    check("rst_level", level, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    valid  = 1'b1;
    sample = 8'h55;
    repeat (50) cycle();
    valid = 1'b0;

    // Prime with eight 0x40 samples, then expect 64/256 duty.
    enable = 1'b1;
    push_n(8, 8'h40);
    guard = 0;
    while (!(m_state == PLAY && m_duty_next == 8'h40) && guard < 2000) begin
      cycle();
      guard++;
    end
    check("tmo_play", int'(guard < 2000), 1);
    measure_highs(highs);
    check("duty_0x40", highs, 64);

    // Overfill: ready must drop at full and extra valids are refused.
    saw_full = 1'b0;
    valid    = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (level == 5'd16) saw_full = 1'b1;
    end
    valid = 1'b0;
    check("fifo_full_seen", saw_full, 1);

    // Drain to underrun; duty falls back to midscale; clear the flag.
    guard = 0;
    while (!m_underrun && guard < 6000) begin
      cycle();
      guard++;
    end
    check("tmo_underrun", int'(guard < 6000), 1);
    check("underrun_set", underrun, 1);
    cycle();
    measure_highs(highs);
    check("duty_mid", highs, 128);
    check("prime_sdn", sd_n, 1);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("underrun_clr", underrun, 0);

    // 0x00 then 0xFF: the rise must line up with the PWM wrap.
    push_n(1, 8'h00);
    push_n(7, 8'hFF);
    guard = 0;
    while (!(m_state == PLAY && m_duty_active == 0) && guard < 3000) begin
      cycle();
      guard++;
    end
    check("tmo_zero", int'(guard < 3000), 1);
    guard = 0;
    while (pwm !== 1'b1 && guard < 1000) begin
      cycle();
      guard++;
    end
    check("tmo_rise", int'(guard < 1000), 1);
    check("rise_at_wrap", m_abs % PER, 1);
    measure_highs(highs);
    check("duty_0xff", highs, 255);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      valid  = 1'($urandom_range(0, 1));
      sample = 8'($urandom);
      clr    = ($urandom_range(0, 63) == 0);
      cycle();
    end
    clr = 1'b0;

    // Reach level 10 in PLAY, then drop enable with a valid pending.
    guard = 0;
    while (!(m_q.size() == 10 && m_state == PLAY) && guard < 5000) begin
      valid  = (m_q.size() < 10);
      sample = 8'($urandom);
      cycle();
      guard++;
    end
    check("tmo_level10", int'(guard < 5000), 1);
    check("pre_drop_level", level, 10);
    enable = 1'b0;
    valid  = 1'b1;
    cycle();
    check("drop_level", level, 0);
    check("drop_sdn", sd_n, 0);
    check("drop_pwm", pwm, 0);
    check("drop_ready", ready, 0);
    repeat (10) cycle();
    valid = 1'b0;

`ifdef AUDIO_PWM_VOLUME_EN
    // Half volume: 0xFF becomes 0xBF.
    enable = 1'b1;
    volume = 3'd1;
    push_n(8, 8'hFF);
    guard = 0;
    while (!(m_state == PLAY && m_duty_next != MIDV) && guard < 2000) begin
      cycle();
      guard++;
    end
    check("tmo_vol", int'(guard < 2000), 1);
    measure_highs(highs);
    check("duty_vol", highs, 191);
`endif

    // Random traffic with occasional disable.
    for (int i = 0; i < 2000; i++) begin
      enable = ($urandom_range(0, 199) != 0);
      valid  = 1'($urandom_range(0, 1));
      sample = 8'($urandom);
      clr    = ($urandom_range(0, 63) == 0);
`ifdef AUDIO_PWM_VOLUME_EN
      if ($urandom_range(0, 99) == 0) volume = 3'($urandom);
`endif
      cycle();
    end
    enable = 1'b1;
    clr    = 1'b0;
    valid  = 1'b1;
    repeat (40) cycle();

    // Asynchronous reset between clock edges.
    #5 rst_n = 1'b0;
    #1;
    check("arst_pwm", pwm, 0);
    check("arst_sdn", sd_n, 0);
    check("arst_ready", ready, 0);
    check("arst_under", underrun, 0);
    check("arst_level", level, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
